// File: rtl/gpio_input_ctrl_pkg.sv
// Shared constants and width helpers for the multi-channel GPIO input front end.
package gpio_in_pkg;

  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_DEBOUNCE_CYC = 1000;
  localparam int DEF_FIFO_DEPTH   = 4;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // A single channel still needs a one-bit id field so the event layout never collapses.
  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 32'sd1;
  endfunction

  function automatic int event_w(input int num_ch, input int data_w);
    return ch_id_w(num_ch) + data_w;
  endfunction

  localparam int DEF_CH_ID_W = ch_id_w(DEF_NUM_CH);

  typedef struct packed {
    logic [DEF_CH_ID_W-1:0] id;
    logic [DEF_DATA_W-1:0]  data;
  } gpio_event_t;

endpackage

// File: rtl/gpio_input_ctrl_if.sv
// CPU-facing pop/status bus of the GPIO input controller.
interface gpio_input_ctrl_if import gpio_in_pkg::*; #(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int EVT_W = event_w(NUM_CH, DATA_W);
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic             clr_overflow;
  logic [EVT_W-1:0] rd_data;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output rd_en, clr_overflow,
    input  rd_data, empty, count, overflow
  );

  modport slave (
    input  rd_en, clr_overflow,
    output rd_data, empty, count, overflow
  );

endinterface

// File: rtl/gpio_input_ctrl_debouncer.sv
// Per-channel strobe conditioner: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on the cycle the level rises.
module input_debouncer import gpio_in_pkg::*; #(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic rise_o
);

  localparam int               CNT_W    = clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 32'sd1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_s;

  assign strobe_s = sync_q[1];

  // Count only while the synced strobe disagrees with the debounced level.
  always_comb begin
    sync_d  = {sync_q[0], strobe_i};
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    if (strobe_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = strobe_s;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // The capture happens on the same edge the level rises, so the pulse comes from _d.
  assign rise_o = level_d & ~level_q;

  // Synchroniser, debounced level and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_input_ctrl.sv
// Multi-channel GPIO input front end: debounced strobe capture per channel,
// fixed-priority arbitration into a small show-ahead event FIFO.
module gpio_input_ctrl import gpio_in_pkg::*; #(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_strobe,
  gpio_input_ctrl_if.slave         bus
);

  localparam int               CH_ID_W  = ch_id_w(NUM_CH);
  localparam int               EVT_W    = CH_ID_W + DATA_W;
  localparam int               PTR_W    = clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);

  logic [NUM_CH*DATA_W-1:0] data_s1_q, data_s1_d;
  logic [NUM_CH*DATA_W-1:0] data_s2_q, data_s2_d;
  logic [NUM_CH-1:0]        rise_s;
  logic [DATA_W-1:0]        hold_q [NUM_CH];
  logic [DATA_W-1:0]        hold_d [NUM_CH];
  logic [NUM_CH-1:0]        pending_q, pending_d;

  logic [EVT_W-1:0]         mem_q [FIFO_DEPTH];
  logic [EVT_W-1:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     empty_q, empty_d;
  logic                     overflow_q, overflow_d;
  logic [EVT_W-1:0]         rd_data_q, rd_data_d;

  logic                     grant_vld_s;
  logic [CH_ID_W-1:0]       grant_id_s;
  logic [EVT_W-1:0]         push_evt_s;
  logic                     full_s, pop_s, push_s, drop_s, press_ovf_s;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst),
      .strobe_i (ch_strobe[gi]),
      .rise_o   (rise_s[gi])
    );
  end

  // Fixed priority: scanning downward leaves the lowest pending index as the winner.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = {CH_ID_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      grant_id_s  = pending_q[i] ? CH_ID_W'(i) : grant_id_s;
      grant_vld_s = grant_vld_s | pending_q[i];
    end
    push_evt_s = {grant_id_s, hold_q[grant_id_s]};
  end

  // Data synchronisers, holding registers and pending flags.
  always_comb begin
    data_s1_d   = ch_data;
    data_s2_d   = data_s1_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    press_ovf_s = 1'b0;
    if (grant_vld_s) begin
      pending_d[grant_id_s] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise_s[i]) begin
        hold_d[i]    = data_s2_q[i*DATA_W +: DATA_W];
        pending_d[i] = 1'b1;
        // A press landing on an unconsumed event loses the older one.
        if (pending_q[i] && !(grant_vld_s && (grant_id_s == CH_ID_W'(i)))) begin
          press_ovf_s = 1'b1;
        end else begin
          press_ovf_s = press_ovf_s;
        end
      end else begin
        hold_d[i] = hold_q[i];
      end
    end
  end

  // FIFO control; a push into a full queue is still accepted when a pop frees the head slot.
  always_comb begin
    full_s   = (count_q == CNT_FULL);
    pop_s    = bus.rd_en & ~empty_q;
    push_s   = grant_vld_s & (~full_s | pop_s);
    drop_s   = grant_vld_s & full_s & ~pop_s;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_evt_s;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d   = (count_d == CNT_ZERO);
    rd_data_d = mem_d[rd_ptr_d];
    if (drop_s || press_ovf_s) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // All state, including the registered head/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_s1_q  <= {(NUM_CH*DATA_W){1'b0}};
      data_s2_q  <= {(NUM_CH*DATA_W){1'b0}};
      pending_q  <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= {DATA_W{1'b0}};
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_q[j] <= {EVT_W{1'b0}};
      end
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= CNT_ZERO;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      rd_data_q  <= {EVT_W{1'b0}};
    end else begin
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Scoreboard bench for gpio_input_ctrl: expected events are queued at press time
// and compared by a monitor whenever a pop is presented to the DUT.
module tb_gpio_input_ctrl;
  import gpio_in_pkg::*;

  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int EW    = 9;

  logic          clk;
  logic          rst;
  logic [15:0]   ch_data;
  logic [1:0]    ch_strobe;
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q [$];

  gpio_input_ctrl_if #(.NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  gpio_input_ctrl #(
    .NUM_CH       (NCH),
    .DATA_W       (DW),
    .DEBOUNCE_CYC (DEB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_data   (ch_data),
    .ch_strobe (ch_strobe),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [EW-1:0] mk(input logic id, input logic [7:0] d);
    gpio_event_t e;
    e.id   = id;
    e.data = d;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Lands 1 time unit after the n-th rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int ch, input logic [7:0] d, input int hold);
    ch_data[ch*8 +: 8] = d;
    ch_strobe[ch]      = 1'b1;
    step(hold);
    ch_strobe[ch]      = 1'b0;
  endtask

  // Monitor: every accepted pop must match the oldest expected event.
  always @(negedge clk) begin : mon
    logic [EW-1:0] exp_ev;
    if (rst && bus.rd_en && !bus.empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", bus.rd_data);
      end else begin
        exp_ev = exp_q.pop_front();
        if (bus.rd_data !== exp_ev) begin
          errors++;
          $display("FAIL pop_data actual=%0h required=%0h", bus.rd_data, exp_ev);
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    ch_data          = 16'h0000;
    ch_strobe        = 2'b00;
    bus.rd_en        = 1'b0;
    bus.clr_overflow = 1'b0;
    #2 rst = 1'b0;
    step(3);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    rst = 1'b1;
    step(2);

    // Single press with latency check
    ch_data[7:0] = 8'hfc;
    ch_strobe[0] = 1'b1;
    exp_q.push_back(mk(1'b0, 8'hfc));
    step(6);
    chk("t1_empty_before", 32'(bus.empty), 32'd1);
    step(1);
    chk("t1_empty_after", 32'(bus.empty), 32'd0);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_rd_data", 32'(bus.rd_data), 32'(mk(1'b0, 8'hfc)));
    step(13);
    ch_strobe[0] = 1'b0;
    step(10);
    chk("t1_single_event", 32'(bus.count), 32'd1);
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
    chk("t1_empty_pop", 32'(bus.empty), 32'd1);
    chk("t1_count_pop", 32'(bus.count), 32'd0);

    // Glitch shorter than the debounce window
    press(1, 8'h77, 3);
    step(12);
    chk("t2_count", 32'(bus.count), 32'd0);
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // Simultaneous presses, ch0 wins first
    ch_data   = {8'h22, 8'h11};
    ch_strobe = 2'b11;
    exp_q.push_back(mk(1'b0, 8'h11));
    exp_q.push_back(mk(1'b1, 8'h22));
    step(7);
    chk("t3_count1", 32'(bus.count), 32'd1);
    chk("t3_head", 32'(bus.rd_data), 32'(mk(1'b0, 8'h11)));
    step(1);
    chk("t3_count2", 32'(bus.count), 32'd2);
    step(4);
    ch_strobe = 2'b00;
    step(10);
    bus.rd_en = 1'b1;
    step(2);
    bus.rd_en = 1'b0;
    chk("t3_empty", 32'(bus.empty), 32'd1);
    chk("t3_overflow", 32'(bus.overflow), 32'd0);

    // Five presses into a four-deep queue
    for (int p = 0; p < 5; p++) begin
      if (p < 4) begin
        exp_q.push_back(mk(1'b0, 8'ha0 + 8'(p)));
      end
      press(0, 8'ha0 + 8'(p), 8);
      step(8);
    end
    chk("t4_count", 32'(bus.count), 32'd4);
    chk("t4_overflow", 32'(bus.overflow), 32'd1);
    chk("t4_head", 32'(bus.rd_data), 32'(mk(1'b0, 8'ha0)));
    bus.clr_overflow = 1'b1;
    step(1);
    bus.clr_overflow = 1'b0;
    chk("t4_clr", 32'(bus.overflow), 32'd0);

    // Full queue: push coincides with a pop
    ch_data[7:0] = 8'hb5;
    ch_strobe[0] = 1'b1;
    exp_q.push_back(mk(1'b0, 8'hb5));
    step(6);
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
    chk("t5_count", 32'(bus.count), 32'd4);
    chk("t5_overflow", 32'(bus.overflow), 32'd0);
    chk("t5_head", 32'(bus.rd_data), 32'(mk(1'b0, 8'ha1)));
    step(5);
    ch_strobe[0] = 1'b0;
    step(10);
    bus.rd_en = 1'b1;
    step(4);
    chk("t5_drained", 32'(bus.empty), 32'd1);
    step(1);
    bus.rd_en = 1'b0;
    chk("t5_pop_empty_count", 32'(bus.count), 32'd0);
    chk("t5_pop_empty_flag", 32'(bus.empty), 32'd1);

    // Reset in the middle of a debounce with two entries queued
    exp_q.push_back(mk(1'b0, 8'hc1));
    press(0, 8'hc1, 8);
    step(8);
    exp_q.push_back(mk(1'b0, 8'hc2));
    press(0, 8'hc2, 8);
    step(8);
    chk("t6_count_pre", 32'(bus.count), 32'd2);
    ch_strobe[1] = 1'b1;
    step(3);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    ch_strobe[1] = 1'b0;
    step(2);
    rst = 1'b1;
    step(15);
    chk("t6_no_event", 32'(bus.count), 32'd0);
    ch_data[15:8] = 8'h5a;
    ch_strobe[1]  = 1'b1;
    exp_q.push_back(mk(1'b1, 8'h5a));
    step(6);
    chk("t6_empty_before", 32'(bus.empty), 32'd1);
    step(1);
    chk("t6_count_new", 32'(bus.count), 32'd1);
    chk("t6_head", 32'(bus.rd_data), 32'(mk(1'b1, 8'h5a)));
    step(3);
    ch_strobe[1] = 1'b0;
    step(8);
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
    chk("t6_empty_end", 32'(bus.empty), 32'd1);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
